axis_packet_arbiter: RTL and testbench

Parametrised N-input AXI-Stream packet arbiter that merges host command streams (serial, FT245/FMC, future links) into one 32-bit stream for the rasterizer command parser. Successor to the ad-hoc valid-driven mux: grant is locked per packet until the input's tlast, with fixed-priority or round-robin selection and a per-channel enable mask. Also has a beat watchdog that force-terminates runaway packets and a registered skid-buffer output for full throughput. Sits between the host-interface adapters and the command decoder.

---
 rtl/rasterix_axis_pkg.sv | 15 +
 rtl/axis_skid_buffer.sv | 64 ++++++
 rtl/axis_packet_arbiter.sv | 134 +++++++++++++
 tb/tb_axis_packet_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterix_axis_pkg.sv
// Shared constants and width helpers for the rasterix AXI-Stream stages.
package rasterix_axis_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Ceiling log2 that never returns less than 1, so single-entry indices still get a bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer (output register + overflow slot), 1-cycle latency, 1 beat/cycle.
// in_rdy depends only on registered occupancy; out_dat holds while out_vld && !out_rdy.
module axis_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             aclk,
   input  logic             resetn,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_dat,
   output logic             occupied
);

   logic             out_vld_q, out_vld_d;
   logic             skid_vld_q, skid_vld_d;
   logic [WIDTH-1:0] out_dat_q, out_dat_d;
   logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
   logic             accept;

   always_comb begin
      accept     = in_vld && !skid_vld_q;
      out_vld_d  = out_vld_q;
      out_dat_d  = out_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (!out_vld_q || out_rdy) begin
         // Output slot frees up: the parked beat goes first so order is preserved.
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = skid_dat_q;
            skid_vld_d = 1'b0;
         end else begin
            out_vld_d = accept;
            if (accept) out_dat_d = in_dat;
         end
      end else if (accept) begin
         skid_vld_d = 1'b1;
         skid_dat_d = in_dat;
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_dat_q  <= '0;
         skid_dat_q <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         out_dat_q  <= out_dat_d;
         skid_dat_q <= skid_dat_d;
      end
   end

   assign in_rdy   = !skid_vld_q;
   assign out_vld  = out_vld_q;
   assign out_dat  = out_dat_q;
   assign occupied = out_vld_q | skid_vld_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// N:1 AXI-Stream arbiter, grant locked per packet, beat watchdog, skid-buffered output.
// One arbitration cycle per packet, 1-cycle data latency; input ready tracks registered buffer space.
module axis_packet_arbiter
   import rasterix_axis_pkg::*;
#(
   parameter int S_COUNT    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int ARB_MODE   = ARB_RR,
   parameter int MAX_BEATS  = 0,
   parameter int ID_WIDTH   = clog2_min1(S_COUNT)
) (
   input  logic                          aclk,
   input  logic                          resetn,
   input  logic [S_COUNT-1:0]            ch_enable,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [ID_WIDTH-1:0]           m_axis_tid,
   output logic                          busy,
   output logic                          wdg_trip
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;
   localparam int         CNT_W     = clog2_min1(MAX_BEATS + 1);
   localparam logic [CNT_W:0] BEAT_LIMIT = (CNT_W + 1)'(MAX_BEATS);
   localparam int         SKID_W    = DATA_WIDTH + ID_WIDTH + 1;

   logic [0:0]            state_q, state_d;
   logic [ID_WIDTH-1:0]   grant_q, grant_d;
   logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0]   win_idx;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [CNT_W:0]        beat_num;
   logic [S_COUNT-1:0]    req, grant_oh;
   logic                  win_found, sel_vld, sel_last, out_last;
   logic                  skid_in_vld, skid_in_rdy, skid_busy;
   logic [DATA_WIDTH-1:0] sel_dat;
   logic [SKID_W-1:0]     skid_out_dat;
   int                    cand;

   // rr_ptr_q is the first channel looked at, so a fresh reset favours channel 0.
   always_comb begin
      req       = s_axis_tvalid & ch_enable;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         cand = (ARB_MODE == ARB_RR) ? (int'(rr_ptr_q) + i) % S_COUNT : i;
         if (!win_found && |(req & (S_COUNT'(1) << cand))) begin
            win_found = 1'b1;
            win_idx   = ID_WIDTH'(cand);
         end
      end
   end

   always_comb begin
      grant_oh = S_COUNT'(1) << grant_q;
      sel_vld  = |(s_axis_tvalid & grant_oh);
      sel_last = |(s_axis_tlast & grant_oh);
      sel_dat  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      beat_cnt_d    = beat_cnt_q;
      s_axis_tready = '0;
      skid_in_vld   = 1'b0;
      out_last      = sel_last;
      wdg_trip      = 1'b0;
      beat_num      = {1'b0, beat_cnt_q} + 1'b1;
      if (state_q == ST_IDLE) begin
         if (win_found) begin
            state_d  = ST_LOCKED;
            grant_d  = win_idx;
            rr_ptr_d = ID_WIDTH'((int'(win_idx) + 1) % S_COUNT);
         end
      end else begin
         s_axis_tready = grant_oh & {S_COUNT{skid_in_rdy}};
         skid_in_vld   = sel_vld;
         if (sel_vld && skid_in_rdy) begin
            beat_cnt_d = beat_num[CNT_W-1:0];
            // A runaway packet is cut at the limit; its tail re-arbitrates as a new packet.
            if ((MAX_BEATS > 0) && (beat_num == BEAT_LIMIT) && !sel_last) begin
               out_last = 1'b1;
               wdg_trip = 1'b1;
            end
            if (out_last) begin
               state_d    = ST_IDLE;
               beat_cnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   axis_skid_buffer #(
      .WIDTH (SKID_W)
   ) u_skid (
      .aclk     (aclk),
      .resetn   (resetn),
      .in_vld   (skid_in_vld),
      .in_rdy   (skid_in_rdy),
      .in_dat   ({sel_dat, grant_q, out_last}),
      .out_vld  (m_axis_tvalid),
      .out_rdy  (m_axis_tready),
      .out_dat  (skid_out_dat),
      .occupied (skid_busy)
   );

   assign {m_axis_tdata, m_axis_tid, m_axis_tlast} = skid_out_dat;
   assign busy = (state_q == ST_LOCKED) | skid_busy;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter: 2-ch RR with watchdog, plus 4-ch RR and 4-ch fixed-priority instances.
module tb_axis_packet_arbiter;
   import rasterix_axis_pkg::*;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;
   logic resetn;

   // 2-channel round-robin, watchdog at 4 beats
   logic [1:0]  a_en, a_svld, a_srdy, a_slast;
   logic [63:0] a_sdat;
   logic        a_mvld, a_mrdy, a_mlast, a_busy, a_trip;
   logic [31:0] a_mdat;
   logic [0:0]  a_mtid;

   // 4-channel round-robin and fixed priority share the input streams
   logic [3:0]   s4_vld, s4_last, b_en, c_en, b_srdy, c_srdy;
   logic [127:0] s4_dat;
   logic         b_mvld, b_mrdy, b_mlast, b_busy, b_trip;
   logic         c_mvld, c_mrdy, c_mlast, c_busy, c_trip;
   logic [31:0]  b_mdat, c_mdat;
   logic [1:0]   b_mtid, c_mtid;

   axis_packet_arbiter #(.S_COUNT(2), .DATA_WIDTH(32), .ARB_MODE(ARB_RR), .MAX_BEATS(4)) dut_a (
      .aclk(aclk), .resetn(resetn), .ch_enable(a_en), .s_axis_tvalid(a_svld), .s_axis_tready(a_srdy),
      .s_axis_tlast(a_slast), .s_axis_tdata(a_sdat), .m_axis_tvalid(a_mvld), .m_axis_tready(a_mrdy),
      .m_axis_tlast(a_mlast), .m_axis_tdata(a_mdat), .m_axis_tid(a_mtid), .busy(a_busy), .wdg_trip(a_trip));

   axis_packet_arbiter #(.S_COUNT(4), .DATA_WIDTH(32), .ARB_MODE(ARB_RR), .MAX_BEATS(0)) dut_b (
      .aclk(aclk), .resetn(resetn), .ch_enable(b_en), .s_axis_tvalid(s4_vld), .s_axis_tready(b_srdy),
      .s_axis_tlast(s4_last), .s_axis_tdata(s4_dat), .m_axis_tvalid(b_mvld), .m_axis_tready(b_mrdy),
      .m_axis_tlast(b_mlast), .m_axis_tdata(b_mdat), .m_axis_tid(b_mtid), .busy(b_busy), .wdg_trip(b_trip));

   axis_packet_arbiter #(.S_COUNT(4), .DATA_WIDTH(32), .ARB_MODE(ARB_FIXED), .MAX_BEATS(0)) dut_c (
      .aclk(aclk), .resetn(resetn), .ch_enable(c_en), .s_axis_tvalid(s4_vld), .s_axis_tready(c_srdy),
      .s_axis_tlast(s4_last), .s_axis_tdata(s4_dat), .m_axis_tvalid(c_mvld), .m_axis_tready(c_mrdy),
      .m_axis_tlast(c_mlast), .m_axis_tdata(c_mdat), .m_axis_tid(c_mtid), .busy(c_busy), .wdg_trip(c_trip));

   typedef struct {
      logic [1:0] vld;  logic [7:0] d0;  logic [7:0] d1;  logic [1:0] last;  logic mrdy;
      logic [1:0] srdy; logic mvld; logic [7:0] mdat; logic tid; logic mlast; logic busy;
   } vec_t;

   typedef struct packed { logic [31:0] d; logic tid; logic last; } exp_t;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      a_en = '0; a_svld = '0; a_slast = '0; a_sdat = '0; a_mrdy = 1'b0;
      s4_vld = '0; s4_last = '0; s4_dat = '0; b_en = '0; c_en = '0; b_mrdy = 1'b0; c_mrdy = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   vec_t        tbl[15];
   logic [1:0]  qb[$], qc[$];
   exp_t        expq[$];
   exp_t        e;
   logic [31:0] out_d[16];
   logic        out_l[16];
   logic [1:0]  out_t[16];
   int          out_c[16];
   logic [3:0]  pat;
   logic [34:0] prev;
   logic [3:0]  saved;
   bit          prev_stall, found, lastb, exp_trip;
   int          k, n_out, n_trip, trip_beat, cyc, total, n_rcv;
   int          m_grant, m_ptr, m_cnt;
   bit          m_idle;
   logic [1:0]  req;
   logic [31:0] src_d[2][64];
   logic        src_l[2][64];
   int          src_len[2], src_pos[2];
   bit          present[2];

   initial begin
      // rows: vld, d0, d1, last, mrdy | srdy, mvld, mdat, tid, mlast, busy
      tbl[0]  = '{2'b10, 8'h00, 8'h11, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{2'b10, 8'h00, 8'h11, 2'b00, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{2'b10, 8'h00, 8'h12, 2'b00, 1'b1, 2'b10, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{2'b10, 8'h00, 8'h13, 2'b00, 1'b1, 2'b10, 1'b1, 8'h12, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{2'b10, 8'h00, 8'h14, 2'b10, 1'b1, 2'b10, 1'b1, 8'h13, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b1, 8'h14, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{2'b01, 8'h21, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{2'b01, 8'h21, 8'h00, 2'b00, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{2'b11, 8'h22, 8'h31, 2'b10, 1'b1, 2'b01, 1'b1, 8'h21, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{2'b11, 8'h23, 8'h31, 2'b11, 1'b1, 2'b01, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{2'b10, 8'h00, 8'h31, 2'b10, 1'b1, 2'b00, 1'b1, 8'h23, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{2'b10, 8'h00, 8'h31, 2'b10, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[13] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b1, 8'h31, 1'b1, 1'b1, 1'b1};
      tbl[14] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

      // Reset values of every instance
      resetn = 1'b0;
      a_en = '0; a_svld = '0; a_slast = '0; a_sdat = '0; a_mrdy = 1'b1;
      s4_vld = '1; s4_last = '0; s4_dat = '0; b_en = '1; c_en = '1; b_mrdy = 1'b1; c_mrdy = 1'b1;
      tick();
      tick();
      check_eq("reset_a", 64'({a_mvld, a_mlast, a_mdat, a_mtid, a_srdy, a_busy, a_trip}), 64'd0);
      check_eq("reset_b", 64'({b_mvld, b_mlast, b_mdat, b_mtid, b_srdy, b_busy, b_trip}), 64'd0);
      check_eq("reset_c", 64'({c_mvld, c_mlast, c_mdat, c_mtid, c_srdy, c_busy, c_trip}), 64'd0);
      do_reset();

      // Single packet and packet lock, cycle by cycle
      a_en = 2'b11;
      for (int r = 0; r < 15; r++) begin
         a_svld  = tbl[r].vld;
         a_sdat  = {24'h0, tbl[r].d1, 24'h0, tbl[r].d0};
         a_slast = tbl[r].last;
         a_mrdy  = tbl[r].mrdy;
         #1;
         check_eq($sformatf("vec_row%0d", r),
            64'({a_srdy, a_mvld, (a_mvld ? a_mdat : 32'h0), (a_mvld ? a_mtid : 1'b0),
                 (a_mvld ? a_mlast : 1'b0), a_busy, a_trip}),
            64'({tbl[r].srdy, tbl[r].mvld, (tbl[r].mvld ? {24'h0, tbl[r].mdat} : 32'h0),
                 tbl[r].tid, tbl[r].mlast, tbl[r].busy, 1'b0}));
         tick();
      end

      // Round-robin vs fixed priority, all four channels sending 1-beat packets
      do_reset();
      s4_vld = 4'hF; s4_last = 4'hF; b_en = 4'hF; c_en = 4'hF; b_mrdy = 1'b1; c_mrdy = 1'b1;
      for (int i = 0; i < 4; i++) s4_dat[i*32 +: 32] = 32'hC0 + 32'(i);
      for (int t = 0; t < 24; t++) begin
         #1;
         if (b_mvld) qb.push_back(b_mtid);
         if (c_mvld) qc.push_back(c_mtid);
         tick();
      end
      check_eq("rr_count_ok", 64'(qb.size() >= 8), 64'd1);
      check_eq("fp_count_ok", 64'(qc.size() >= 8), 64'd1);
      for (int i = 0; i < 8 && i < qb.size() && i < qc.size(); i++) begin
         check_eq($sformatf("rr_tid%0d", i), 64'(qb[i]), 64'(i % 4));
         check_eq($sformatf("fp_tid%0d", i), 64'(qc[i]), 64'd0);
      end

      // Backpressure on an 8-beat packet, m_axis_tready pattern 1,0,0,1
      do_reset();
      b_en = 4'hF; pat = 4'b1001; k = 0; n_out = 0; prev_stall = 1'b0; prev = '0;
      for (cyc = 0; cyc < 80 && n_out < 8; cyc++) begin
         s4_vld  = (k < 8) ? 4'b0100 : 4'b0000;
         s4_dat  = '0;
         s4_dat[64 +: 32] = 32'h40 + 32'(k);
         s4_last = (k == 7) ? 4'b0100 : 4'b0000;
         b_mrdy  = pat[cyc % 4];
         #1;
         saved  = b_srdy;
         b_mrdy = ~b_mrdy;
         #1;
         check_eq("bp_rdy_no_comb", 64'(b_srdy), 64'(saved));
         b_mrdy = ~b_mrdy;
         #1;
         if (prev_stall) check_eq("bp_stall_hold", 64'({b_mvld, b_mdat, b_mtid, b_mlast}), 64'({1'b1, prev}));
         prev_stall = b_mvld && !b_mrdy;
         prev       = {b_mdat, b_mtid, b_mlast};
         if (b_mvld && b_mrdy) begin
            out_d[n_out] = b_mdat; out_t[n_out] = b_mtid; out_l[n_out] = b_mlast;
            n_out++;
         end
         if (b_srdy[2] && s4_vld[2]) k++;
         tick();
      end
      check_eq("bp_count", 64'(n_out), 64'd8);
      for (int i = 0; i < n_out; i++)
         check_eq($sformatf("bp_beat%0d", i), 64'({out_d[i], out_t[i], out_l[i]}),
                  64'({32'h40 + 32'(i), 2'd2, (i == 7)}));

      // Watchdog: 6 beats without tlast, then a closing beat
      do_reset();
      a_en = 2'b11; a_mrdy = 1'b1; k = 0; n_out = 0; n_trip = 0; trip_beat = -1;
      for (cyc = 0; cyc < 60 && n_out < 7; cyc++) begin
         a_svld  = (k < 7) ? 2'b01 : 2'b00;
         a_sdat  = {32'h0, 32'h51 + 32'(k)};
         a_slast = (k == 6) ? 2'b01 : 2'b00;
         #1;
         if (a_trip) begin n_trip++; trip_beat = k; end
         if (a_mvld) begin
            out_d[n_out] = a_mdat; out_t[n_out] = {1'b0, a_mtid}; out_l[n_out] = a_mlast; out_c[n_out] = cyc;
            n_out++;
         end
         if (a_srdy[0] && a_svld[0]) k++;
         tick();
      end
      check_eq("wdg_count", 64'(n_out), 64'd7);
      for (int i = 0; i < n_out; i++)
         check_eq($sformatf("wdg_beat%0d", i), 64'({out_d[i], out_t[i], out_l[i]}),
                  64'({32'h51 + 32'(i), 2'd0, (i == 3 || i == 6)}));
      check_eq("wdg_trip_count", 64'(n_trip), 64'd1);
      check_eq("wdg_trip_beat", 64'(trip_beat), 64'd3);
      if (n_out == 7) begin
         check_eq("wdg_contiguous", 64'(out_c[3] - out_c[2]), 64'd1);
         check_eq("wdg_rearb_gap", 64'(out_c[4] - out_c[3]), 64'd2);
      end

      // Disabled channel is never granted
      a_svld = 2'b00;
      tick();
      tick();
      a_en = 2'b10; a_svld = 2'b01; a_slast = 2'b01;
      for (int t = 0; t < 8; t++) begin
         #1;
         check_eq("mask_ch0", 64'({a_srdy, a_mvld, a_busy}), 64'd0);
         tick();
      end

      // Asynchronous reset in the middle of a packet
      do_reset();
      a_en = 2'b11; a_mrdy = 1'b1; k = 0;
      for (cyc = 0; cyc < 20 && k < 2; cyc++) begin
         a_svld = 2'b01; a_sdat = {32'h0, 32'h61 + 32'(k)}; a_slast = 2'b00;
         #1;
         if (a_srdy[0] && a_svld[0]) k++;
         tick();
      end
      check_eq("arst_pre", 64'({a_mvld, a_busy, a_mdat}), 64'({2'b11, 32'h62}));
      #2;
      resetn = 1'b0;
      #1;
      check_eq("arst_now", 64'({a_mvld, a_srdy, a_busy, a_mdat, a_mlast}), 64'd0);
      tick();
      resetn = 1'b1;
      a_svld = 2'b11; a_slast = 2'b11; a_sdat = {32'h72, 32'h71};
      found = 1'b0;
      for (cyc = 0; cyc < 10 && !found; cyc++) begin
         #1;
         if (a_mvld) begin
            found = 1'b1;
            check_eq("arst_first_tid", 64'({a_mtid, a_mdat}), 64'({1'b0, 32'h71}));
         end
         tick();
      end
      check_eq("arst_output_seen", 64'(found), 64'd1);

      // Randomised traffic against a packet-level model
      do_reset();
      a_en = 2'b11;
      total = 0;
      for (int ch = 0; ch < 2; ch++) begin
         src_len[ch] = 0; src_pos[ch] = 0; present[ch] = 1'b0;
         for (int p = 0; p < 6; p++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) begin
               src_d[ch][src_len[ch]] = (32'(ch) << 16) | 32'(src_len[ch]);
               src_l[ch][src_len[ch]] = (b == len - 1);
               src_len[ch]++;
            end
         end
         total += src_len[ch];
      end
      m_idle = 1'b1; m_ptr = 0; m_cnt = 0; m_grant = 0; n_rcv = 0;
      for (cyc = 0; cyc < 4000 && n_rcv < total; cyc++) begin
         for (int ch = 0; ch < 2; ch++)
            if (!present[ch] && src_pos[ch] < src_len[ch] && $urandom_range(0, 3) != 0) present[ch] = 1'b1;
         a_svld  = {present[1], present[0]};
         a_sdat  = {src_d[1][src_pos[1]], src_d[0][src_pos[0]]};
         a_slast = {src_l[1][src_pos[1]], src_l[0][src_pos[0]]};
         a_mrdy  = ($urandom_range(0, 3) != 0);
         #1;
         exp_trip = 1'b0;
         if (m_idle) begin
            check_eq("rand_idle_rdy", 64'(a_srdy), 64'd0);
            req = a_svld & a_en;
            if (req != 2'b00) begin
               m_grant = req[m_ptr] ? m_ptr : 1 - m_ptr;
               m_ptr   = (m_grant + 1) % 2;
               m_idle  = 1'b0;
            end
         end else begin
            check_eq("rand_lock_rdy", 64'(a_srdy & ~(2'b01 << m_grant)), 64'd0);
            if (a_srdy[m_grant] && a_svld[m_grant]) begin
               m_cnt++;
               lastb    = a_slast[m_grant];
               exp_trip = !lastb && (m_cnt == 4);
               e.d      = a_sdat[m_grant*32 +: 32];
               e.tid    = 1'(m_grant);
               e.last   = lastb || exp_trip;
               expq.push_back(e);
               if (e.last) begin m_idle = 1'b1; m_cnt = 0; end
            end
         end
         check_eq("rand_trip", 64'(a_trip), 64'(exp_trip));
         if (a_mvld && a_mrdy) begin
            if (expq.size() == 0) begin
               check_eq("rand_extra_beat", 64'(a_mdat), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = expq.pop_front();
               check_eq("rand_beat", 64'({a_mdat, a_mtid, a_mlast}), 64'({e.d, e.tid, e.last}));
               n_rcv++;
            end
         end
         for (int ch = 0; ch < 2; ch++)
            if (a_srdy[ch] && a_svld[ch]) begin src_pos[ch]++; present[ch] = 1'b0; end
         tick();
      end
      check_eq("rand_all_delivered", 64'({n_rcv, expq.size()}), 64'({total, 32'd0}));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
